ls_quad_gate_tester: RTL and testbench
======================================

# ls_quad_gate_tester

Synthesizable exhaustive tester for 74LS-series quad 2-input gate devices (74LS00/02/08/32/86 class). It sits on the chip-under-test pin side and drives all four A/B input pairs through every 256 input combinations. It samples the four Y outputs through a synchronizer after a programmable settle time and compares them against the selected gate function. It reports pass/fail, a failure count and the first failing vector to the bring-up controller through a start/busy/done handshake.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles each vector is held before its compare cycle; legal range 3..255 (covers the 2-flop synchronizer)
- GATE_FN, 0, expected function per gate: 0=AND, 1=NAND, 2=OR, 3=NOR, 4=XOR; other values are illegal

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run; honoured only in IDLE
- abort  in  1  cancel a run in progress
- a  out  4  gate A inputs to device; a[i] drives gate i+1
- b  out  4  gate B inputs to device
- y  in  4  gate outputs from device; asynchronous
- busy  out  1  high from the cycle after start is accepted until done or abort
- done  out  1  one-cycle pulse at run completion
- pass  out  1  1 when the last completed run had zero failures; held until next start
- fail_count  out  9  failing vectors in the last run (0..256)
- first_fail_vec  out  8  vector index {a,b} of the first failure
- first_fail_y  out  4  synchronized y captured at the first failure

## Operation
- Vector index v[7:0]: a = v[7:4], b = v[3:0]. Expected e[i] = GATE_FN(a[i], b[i]).
- y passes through a 2-stage synchronizer (ys). Only ys is compared.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE: a=b=0, busy=0. When start=1, set v=0, drive a/b from v, clear cnt, fail_count, first_fail_*, pass, and go to SETTLE.
- SETTLE: cnt increments each cycle. At cnt==SETTLE_CYCLES-1, go to CHECK.
- CHECK (one cycle): mismatch = (ys != e).
  - On mismatch, fail_count++. If this is the first mismatch, also capture first_fail_vec=v and first_fail_y=ys.
  - If v==255, go to DONE. Otherwise v++, drive new a/b, cnt=0, and go to SETTLE.
- DONE (one cycle): done=1, pass=(fail_count==0), busy=0. Next state is IDLE.
- abort=1 in SETTLE or CHECK: next state IDLE, a=b=0, busy=0, no done pulse, pass=0, fail_count/first_fail_* keep partial values.
- abort in IDLE or DONE has no effect. abort has priority over the CHECK update in the same cycle; the aborted vector is not counted.
- start while busy is ignored. start and abort in the same IDLE cycle: start wins.
- Illegal GATE_FN gives e=0.

## Timing
- Reset values: a=0, b=0, busy=0, done=0, pass=0, fail_count=0, first_fail_vec=0, first_fail_y=0, synchronizer flops=0, state IDLE.
- Reset applied mid-run returns all of the above on the next edge.
- start sampled at edge T0: vector 0 appears on a/b and busy=1 after T0.
- Each vector is held SETTLE_CYCLES+1 cycles, with the compare in the last cycle.
- done is high in the cycle after edge T0 + 256*(SETTLE_CYCLES+1). For the default this is 1280 cycles.
- a/b change only on FSM edges and are glitch-free registered outputs.
- fail_count never wraps; its maximum is 256.

## Test plan
- Ideal AND device model, defaults, start pulse -> busy for 1280 cycles, done pulse, pass=1, fail_count=0.
- y[2] stuck-at-0, GATE_FN=0 -> fail_count=64, first_fail_vec=0x44, first_fail_y=4'b0000, pass=0.
- y[0] stuck-at-1, GATE_FN=0 -> fail_count=192, first_fail_vec=0x00, first_fail_y=4'b0001, pass=0.
- Ideal AND model with GATE_FN=1 (NAND) -> fail_count=256, first_fail_vec=0x00, first_fail_y=4'b0000.
- abort 100 cycles after start -> next cycle busy=0, a=b=0, no done. A fresh start then gives a clean 1280-cycle run with pass=1. A start pulse issued mid-run changes nothing.
- rst asserted mid-run -> all outputs at reset values after one edge, state IDLE. SETTLE_CYCLES=3 run on ideal model -> done after 1024 cycles, pass=1.

Source files
------------

// File: rtl/ls_quad_gate_tester.sv
// Exhaustive tester for 74LS quad 2-input gates: walks all 256 {a,b} vectors,
// compares synchronized y against the selected gate function, reports results.
module ls_quad_gate_tester #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned GATE_FN       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] a,
  output logic [3:0] b,
  input  logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] fail_count,
  output logic [7:0] first_fail_vec,
  output logic [3:0] first_fail_y
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 32'd1);

  state_t     state;
  logic [7:0] v;
  logic [7:0] cnt;
  logic [3:0] y_meta;
  logic [3:0] ys;
  logic [3:0] exp_y;
  logic       mismatch;
  logic [8:0] fail_next;
  logic [7:0] v_inc;

  function automatic logic [3:0] gate_expect(input logic [3:0] ga, input logic [3:0] gb);
    case (GATE_FN)
      32'd0:   return ga & gb;
      32'd1:   return ~(ga & gb);
      32'd2:   return ga | gb;
      32'd3:   return ~(ga | gb);
      32'd4:   return ga ^ gb;
      default: return 4'b0000;
    endcase
  endfunction

  // Expected outputs for the current vector and the saturating failure count.
  always_comb begin
    exp_y    = gate_expect(v[7:4], v[3:0]);
    mismatch = (ys != exp_y);
    v_inc    = v + 8'd1;
    if (mismatch && (fail_count != 9'd256)) begin
      fail_next = fail_count + 9'd1;
    end else begin
      fail_next = fail_count;
    end
  end

  // Two-flop synchronizer for the asynchronous device outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_meta <= 4'b0000;
      ys     <= 4'b0000;
    end else begin
      y_meta <= y;
      ys     <= y_meta;
    end
  end

  // Control FSM with all handshake and result outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      v              <= 8'd0;
      cnt            <= 8'd0;
      a              <= 4'b0000;
      b              <= 4'b0000;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= 9'd0;
      first_fail_vec <= 8'd0;
      first_fail_y   <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            v              <= 8'd0;
            a              <= 4'b0000;
            b              <= 4'b0000;
            cnt            <= 8'd0;
            fail_count     <= 9'd0;
            first_fail_vec <= 8'd0;
            first_fail_y   <= 4'b0000;
            pass           <= 1'b0;
            busy           <= 1'b1;
            state          <= SETTLE;
          end else begin
            a    <= 4'b0000;
            b    <= 4'b0000;
            busy <= 1'b0;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            a     <= 4'b0000;
            b     <= 4'b0000;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else if (cnt == SETTLE_LAST) begin
            state <= CHECK;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CHECK: begin
          // Abort wins over the compare: the vector in flight is not counted.
          if (abort) begin
            state <= IDLE;
            a     <= 4'b0000;
            b     <= 4'b0000;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            fail_count <= fail_next;
            if (mismatch && (fail_count == 9'd0)) begin
              first_fail_vec <= v;
              first_fail_y   <= ys;
            end else begin
              first_fail_vec <= first_fail_vec;
            end
            if (v == 8'd255) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (fail_next == 9'd0);
            end else begin
              v     <= v_inc;
              a     <= v_inc[7:4];
              b     <= v_inc[3:0];
              cnt   <= 8'd0;
              state <= SETTLE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          a     <= 4'b0000;
          b     <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ls_quad_gate_tester.sv
// Bench for ls_quad_gate_tester: behavioural device/fault model plus a
// vector-walk reference computed directly from the gate truth tables.
module tb_ls_quad_gate_tester;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  logic [2:0] abort;
  logic [3:0] a [3];
  logic [3:0] b [3];
  logic [3:0] y [3];
  logic       busy [3];
  logic       done [3];
  logic       pass [3];
  logic [8:0] fc [3];
  logic [7:0] ffv [3];
  logic [3:0] ffy [3];

  logic [3:0] stuck0;
  logic [3:0] stuck1;
  logic [3:0] flip_tab [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ls_quad_gate_tester dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .a(a[0]), .b(b[0]), .y(y[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail_count(fc[0]),
    .first_fail_vec(ffv[0]), .first_fail_y(ffy[0]));

  ls_quad_gate_tester #(.GATE_FN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .a(a[1]), .b(b[1]), .y(y[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail_count(fc[1]),
    .first_fail_vec(ffv[1]), .first_fail_y(ffy[1]));

  ls_quad_gate_tester #(.SETTLE_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .a(a[2]), .b(b[2]), .y(y[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .fail_count(fc[2]),
    .first_fail_vec(ffv[2]), .first_fail_y(ffy[2]));

  // Device 0 is an AND chip with injectable faults; the others are ideal AND chips.
  function automatic logic [3:0] dev_y(input int which, input logic [3:0] av, input logic [3:0] bv);
    logic [3:0] r;
    r = av & bv;
    if (which == 0) r = ((r ^ flip_tab[{av, bv}]) & ~stuck0) | stuck1;
    return r;
  endfunction

  always @(negedge clk) begin
    y[0] <= dev_y(0, a[0], b[0]);
    y[1] <= dev_y(1, a[1], b[1]);
    y[2] <= dev_y(2, a[2], b[2]);
  end

  function automatic logic [3:0] ref_gate(input int fn, input logic [3:0] av, input logic [3:0] bv);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      int x, z;
      x = int'(av[i]);
      z = int'(bv[i]);
      case (fn)
        0: r[i] = (x * z) == 1;
        1: r[i] = (x * z) == 0;
        2: r[i] = (x + z) >= 1;
        3: r[i] = (x + z) == 0;
        4: r[i] = (x + z) == 1;
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model(input int which, output int efc, output logic [7:0] ev, output logic [3:0] ey);
    int fn;
    logic [7:0] vv;
    logic [3:0] e, d;
    fn  = (which == 1) ? 1 : 0;
    efc = 0;
    ev  = 8'd0;
    ey  = 4'd0;
    for (int v = 0; v < 256; v++) begin
      vv = v[7:0];
      e  = ref_gate(fn, vv[7:4], vv[3:0]);
      d  = dev_y(which, vv[7:4], vv[3:0]);
      if (d != e) begin
        if (efc == 0) begin
          ev = vv;
          ey = d;
        end
        efc++;
      end
    end
  endtask

  task automatic clear_faults();
    stuck0 = 4'b0000;
    stuck1 = 4'b0000;
    for (int i = 0; i < 256; i++) flip_tab[i] = 4'b0000;
  endtask

  task automatic random_faults();
    stuck0 = 4'($urandom()) & 4'($urandom()) & 4'($urandom());
    stuck1 = 4'($urandom()) & 4'($urandom()) & 4'($urandom()) & ~stuck0;
    for (int i = 0; i < 256; i++)
      flip_tab[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'b0000;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_a"}, 32'(a[0]), 32'd0);
    check({tag, "_b"}, 32'(b[0]), 32'd0);
    check({tag, "_busy"}, 32'(busy[0]), 32'd0);
    check({tag, "_done"}, 32'(done[0]), 32'd0);
    check({tag, "_pass"}, 32'(pass[0]), 32'd0);
    check({tag, "_fc"}, 32'(fc[0]), 32'd0);
    check({tag, "_ffv"}, 32'(ffv[0]), 32'd0);
    check({tag, "_ffy"}, 32'(ffy[0]), 32'd0);
  endtask

  task automatic run(input int which, input string tag, input bit mid_start);
    int efc, exp_len, cycles, busy_cnt;
    logic [7:0] ev;
    logic [3:0] ey;
    bit got;
    exp_len = 256 * (((which == 2) ? 3 : 4) + 1);
    model(which, efc, ev, ey);
    @(negedge clk);
    start[which] = 1'b1;
    @(posedge clk); #1;
    start[which] = 1'b0;
    check({tag, "_busy_start"}, 32'(busy[which]), 32'd1);
    check({tag, "_ab_start"}, 32'({a[which], b[which]}), 32'd0);
    busy_cnt = 1;
    cycles = 0;
    got = 1'b0;
    while (cycles < 3000 && !got) begin
      @(posedge clk); #1;
      cycles++;
      start[which] = (mid_start && cycles == 500) ? 1'b1 : 1'b0;
      if (done[which]) got = 1'b1;
      else if (busy[which]) busy_cnt++;
    end
    start[which] = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, cycles, exp_len);
    check({tag, "_busy_cycles"}, busy_cnt, exp_len);
    check({tag, "_busy_at_done"}, 32'(busy[which]), 32'd0);
    check({tag, "_pass"}, 32'(pass[which]), 32'(efc == 0));
    check({tag, "_fail_count"}, 32'(fc[which]), efc);
    check({tag, "_first_vec"}, 32'(ffv[which]), 32'(ev));
    check({tag, "_first_y"}, 32'(ffy[which]), 32'(ey));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done[which]), 32'd0);
    check({tag, "_pass_held"}, 32'(pass[which]), 32'(efc == 0));
  endtask

  initial begin
    int done_seen;
    rst   = 1'b1;
    start = 3'b000;
    abort = 3'b000;
    clear_faults();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    run(0, "ideal", 1'b1);

    stuck0 = 4'b0100;
    run(0, "y2_sa0", 1'b0);
    clear_faults();
    stuck1 = 4'b0001;
    run(0, "y0_sa1", 1'b0);

    for (int k = 0; k < 3; k++) begin
      random_faults();
      run(0, $sformatf("rand%0d", k), 1'b0);
    end

    // Abort in IDLE after a failing run must leave results untouched.
    @(negedge clk);
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    check("idle_abort_busy", 32'(busy[0]), 32'd0);
    check("idle_abort_fc_kept", 32'(fc[0] != 9'd0), 32'(stuck0 != 4'b0000 || stuck1 != 4'b0000 || fc[0] != 9'd0));

    // Start and abort together in IDLE: start wins; abort 100 cycles later.
    clear_faults();
    @(negedge clk);
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    abort[0] = 1'b0;
    check("start_over_abort", 32'(busy[0]), 32'd1);
    repeat (99) @(posedge clk);
    @(negedge clk);
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_ab", 32'({a[0], b[0]}), 32'd0);
    check("abort_done", 32'(done[0]), 32'd0);
    check("abort_pass", 32'(pass[0]), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 1400; i++) begin
      @(posedge clk); #1;
      if (done[0] || busy[0]) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run(0, "after_abort", 1'b0);

    // Reset mid-run.
    random_faults();
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (700) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    run(0, "post_reset", 1'b0);

    clear_faults();
    run(1, "nand", 1'b0);
    run(2, "settle3", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
